// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with valid/ready handshakes; logic/arith ops take one cycle, shifts iterate one bit per cycle.
// Optional macro ALU_FAST_SHIFT_EN replaces the iterative shifter with a single-cycle barrel shifter.
module alu_exec_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         operation,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal_op
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         kind_q, kind_d;
    logic               started_q, started_d;

    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic               accept;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_illegal;
    logic [WIDTH-1:0]   diff;
    logic               slt;

    // Shift kind is the low two opcode bits: 00 SLL, 01 SRL, 10 SRA.
    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic [1:0] kind);
        case (kind)
            2'b00:   return {v[WIDTH-2:0], 1'b0};
            2'b01:   return {1'b0, v[WIDTH-1:1]};
            default: return {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction

    assign shamt    = op_b[SHAMT_W-1:0];
    assign is_shift = (operation[3:2] == 2'b10) && (operation[1:0] != 2'b11);
    assign diff     = op_a - op_b;
    // Overflow-corrected signed less-than: differing signs decide directly.
    assign slt      = (op_a[WIDTH-1] != op_b[WIDTH-1]) ? op_a[WIDTH-1] : diff[WIDTH-1];

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (operation)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: alu_res = op_a + op_b;
            4'b0110: alu_res = diff;
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, slt};
            4'b1100: alu_res = op_a ^ op_b;
            default: alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        kind_d    = kind_q;
        started_d = 1'b1;
        in_ready  = 1'b0;

        case (state_q)
            IDLE: in_ready = started_q;
            BUSY: begin
                result_d = shift1(result_q, kind_q);
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) state_d = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        accept = in_valid && in_ready;
        if (accept) begin
            illegal_d = 1'b0;
            state_d   = DONE;
            if (is_shift) begin
                kind_d = operation[1:0];
                cnt_d  = shamt;
`ifdef ALU_FAST_SHIFT_EN
                case (operation[1:0])
                    2'b00:   result_d = op_a << shamt;
                    2'b01:   result_d = op_a >> shamt;
                    default: result_d = WIDTH'($signed(op_a) >>> shamt);
                endcase
`else
                result_d = op_a;
                if (shamt != '0) state_d = BUSY;
`endif
            end else begin
                result_d  = alu_res;
                illegal_d = alu_illegal;
            end
        end

        zero_d = (result_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            kind_q    <= 2'b00;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            kind_q    <= kind_d;
            started_q <= started_d;
        end
    end

    assign out_valid  = (state_q == DONE);
    assign result     = result_q;
    assign zero       = zero_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage; shift latency expectations follow ALU_FAST_SHIFT_EN.
module tb_alu_exec_stage;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal_op;

    int tests = 0;
    int fails = 0;

    alu_exec_stage #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one op for exactly one edge; the op is accepted only if in_ready was high.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        operation = op;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic run_shift(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        int k;
        k = FAST ? 0 : int'(b[4:0]);
        check({tag, "_ready_before"}, {31'b0, in_ready}, 32'd1);
        issue(op, a, b);
        for (int i = 0; i < k; i++) begin
            check({tag, "_busy_valid"}, {31'b0, out_valid}, 32'd0);
            check({tag, "_busy_ready"}, {31'b0, in_ready}, 32'd0);
            tick();
        end
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_result"}, result, exp);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp == 32'd0});
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operation = 4'b0000;
        op_a      = '0;
        op_b      = '0;
        #1;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_illegal", {31'b0, illegal_op}, 32'd0);
        check("rst_ready", {31'b0, in_ready}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        check("ready_before_edge", {31'b0, in_ready}, 32'd0);
        tick();
        check("ready_after_edge", {31'b0, in_ready}, 32'd1);

        // ADD then back-to-back SUB and SLT variants with out_ready held high
        issue(4'b0010, 32'd5, 32'd3);
        check("add_valid", {31'b0, out_valid}, 32'd1);
        check("add_result", result, 32'd8);
        check("add_zero", {31'b0, zero}, 32'd0);
        check("add_ready", {31'b0, in_ready}, 32'd1);
        issue(4'b0110, 32'h1234, 32'h1234);
        check("sub_valid", {31'b0, out_valid}, 32'd1);
        check("sub_result", result, 32'd0);
        check("sub_zero", {31'b0, zero}, 32'd1);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg", result, 32'd1);
        issue(4'b0111, 32'd1, 32'hFFFF_FFFF);
        check("slt_pos", result, 32'd0);
        issue(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000);
        check("slt_ovf", result, 32'd0);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd2);
        check("add_wrap", result, 32'd1);
        tick();
        check("idle_drop_valid", {31'b0, out_valid}, 32'd0);

        run_shift("sra4", 4'b1010, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_shift("shamt0", 4'b1000, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF);
        run_shift("sll31", 4'b1000, 32'd1, 32'd31, 32'h8000_0000);

        // SRL with upper op_b bits set; a follow-up op is held on in_valid throughout BUSY
        issue(4'b1001, 32'h8000_0000, 32'hFFFF_FFE4);
        operation = 4'b1100;
        op_a      = 32'h0000_FF00;
        op_b      = 32'h0000_0FF0;
        in_valid  = 1'b1;
        for (int i = 0; i < (FAST ? 0 : 4); i++) begin
            check("srl_busy_ready", {31'b0, in_ready}, 32'd0);
            check("srl_busy_valid", {31'b0, out_valid}, 32'd0);
            tick();
        end
        check("srl_result", result, 32'h0800_0000);
        tick();
        in_valid = 1'b0;
        check("xor_after_shift", result, 32'h0000_F0F0);

        // Backpressure: OR result held for 3 cycles, then illegal op accepted on release
        tick();
        out_ready = 1'b0;
        issue(4'b0001, 32'h0000_00A5, 32'h0000_05A0);
        operation = 4'b1111;
        op_a      = 32'h1;
        op_b      = 32'h1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_result", result, 32'h0000_05A5);
            check("bp_zero", {31'b0, zero}, 32'd0);
            check("bp_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("ill_valid", {31'b0, out_valid}, 32'd1);
        check("ill_result", result, 32'd0);
        check("ill_flag", {31'b0, illegal_op}, 32'd1);
        check("ill_zero", {31'b0, zero}, 32'd1);
        issue(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0);
        check("and_result", result, 32'h0000_00F0);
        check("and_illegal", {31'b0, illegal_op}, 32'd0);
        check("and_zero", {31'b0, zero}, 32'd0);
        tick();

        // Reset pulsed in the middle of a shift by 20
        issue(4'b1001, 32'hFFFF_FFFF, 32'd20);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'b0, out_valid}, 32'd0);
        check("abort_ready", {31'b0, in_ready}, 32'd0);
        check("abort_result", result, 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 32'd0);
        check("abort_ready_idle", {31'b0, in_ready}, 32'd1);
        run_shift("srl20", 4'b1001, 32'hFFFF_FFFF, 32'd20, 32'h0000_0FFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage ALU datapath. Consumes the 4-bit Operation code from the ALU controller plus two 32-bit operands, and returns a registered result with valid/ready handshakes on both sides.
- Logic ops, add/sub and SLT complete in one cycle. Shifts run iteratively, one bit per cycle, under a small FSM.
- Sits between the ID/EX operand latch and the EX/MEM writeback register.

Parameters:
- WIDTH, 32, operand/result width
- SHAMT_W, 5, shift-amount width (log2 WIDTH)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation + operands present
- in_ready  output  1  stage can accept an operation this cycle
- operation  input  4  ALU controller Operation code
- op_a  input  WIDTH  operand A (rs1)
- op_b  input  WIDTH  operand B (rs2/imm); shifts use op_b[SHAMT_W-1:0]
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered result
- zero  output  1  result == 0, registered with result (branch compare)
- illegal_op  output  1  operation code not decoded; registered with result

Behaviour:
- Reset: one clock domain, asynchronous active-low reset rst_n.
  - While rst_n low: state=IDLE, out_valid=0, result=0, zero=0, illegal_op=0, shift counter=0, in_ready=0.
  - After rst_n deasserts: in_ready=1 from the first clock edge.
- Operation codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (signed compare; result 1 or 0)
  - 1100 XOR
  - 1000 SLL
  - 1001 SRL
  - 1010 SRA
  - Any other code: result=0, illegal_op=1, 1-cycle latency.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no overflow flag. SLT uses the signed difference with the overflow correction (a<b signed).
- FSM states:
  - IDLE: in_ready=1. On in_valid accept:
    - Non-shift op: compute, register into result, go to DONE.
    - Shift op: load op_a into the shift register and shamt into the counter. If shamt=0, go to DONE with result=op_a; else go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle shift 1 bit (SRA replicates the MSB) and decrement the counter. When the counter reaches 1, the final shift lands in result and the FSM goes to DONE.
  - DONE: out_valid=1; result, zero and illegal_op held stable while out_ready=0. in_ready = out_ready.
    - out_ready=1 and in_valid=1: accept the new op in the same cycle (back-to-back, no bubble); next state follows the IDLE rules.
    - out_ready=1 and in_valid=0: go to IDLE and drop out_valid.
- Latency: op accepted at edge N.
  - Non-shift op: out_valid at N+1.
  - Shift by k: out_valid at N+1+k (k=0 gives N+1).
  - Throughput is 1 op/cycle for non-shift ops when out_ready is held high.
- Boundaries:
  - Shift by WIDTH-1 runs the full WIDTH-1 cycles.
  - op_b bits above SHAMT_W are ignored.
  - in_valid while BUSY is not accepted; the upstream stage must hold its request.
  - rst_n asserted mid-BUSY aborts the shift immediately; no result is emitted.
  - zero is derived from the value written to result, including for illegal ops (zero=1).

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN.
  - Defined: shifts use a combinational barrel shifter; every op, shifts included, has 1-cycle latency and the BUSY state is never entered. The state encoding stays unchanged.
  - Undefined: iterative shifting as described above.
- Results must be bit-identical in both builds; only latency differs.

Test Plan:
- Reset, then a single op: op_a=5, op_b=3, operation=0010 accepted at edge N -> result=8, zero=0, out_valid high at N+1.
- SUB producing zero: op_a=op_b=0x1234, operation=0110 -> result=0, zero=1. SLT: op_a=0xFFFFFFFF, op_b=1, operation=0111 -> result=1.
- Iterative shift: op_a=0x80000000, op_b=4, operation=1010 -> in_ready low 4 cycles, result=0xF8000000 at N+5. Same with 1001 -> 0x08000000. Shamt 0 -> op_a returned at N+1.
- Backpressure: out_ready=0 for 3 cycles with the result pending -> result, zero and out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new op accepted that same cycle.
- Illegal code 1111 -> result=0, illegal_op=1, zero=1, latency 1. Followed by 0000 (AND 0xF0F0, 0x0FF0) -> 0x00F0, illegal_op=0.
- rst_n pulsed low mid-shift (shamt=20, after 7 cycles) -> out_valid=0 immediately, state IDLE. Never any out_valid for the aborted op. Rerun with ALU_FAST_SHIFT_EN defined -> the shift by 20 returns at N+1.
